// File: rtl/controller_sequencer_if.sv
// Control-word bundle between the SAP controller-sequencer and the datapath it steers.
// The sequencer drives the strobes, ring state and halt flag, and receives the IR opcode nibble.
interface controller_sequencer_if;
   logic [3:0] opcode;
   logic       Cp;
   logic       Ep;
   logic       Lm;
   logic       Er;
   logic       Li;
   logic       Ei;
   logic       La;
   logic       Ea;
   logic       Lb;
   logic       Su;
   logic       Eu;
   logic       Lo;
   logic       HLT;
   logic [5:0] tstate;

   modport master (
      input  opcode,
      output Cp, Ep, Lm, Er, Li, Ei, La, Ea, Lb, Su, Eu, Lo, HLT, tstate
   );

   modport slave (
      output opcode,
      input  Cp, Ep, Lm, Er, Li, Ei, La, Ea, Lb, Su, Eu, Lo, HLT, tstate
   );
endinterface

// File: rtl/controller_sequencer.sv
// SAP-1 controller-sequencer: a six-state one-hot ring (T1..T6) plus the opcode decode that
// produces the control word. Control strobes are combinational from ring state and opcode.
module controller_sequencer (
   input  logic                   CLK,
   input  logic                   CLR_n,
   controller_sequencer_if.master bus
);
   localparam logic [3:0] OP_LDA = 4'b0000;
   localparam logic [3:0] OP_ADD = 4'b0001;
   localparam logic [3:0] OP_SUB = 4'b0010;
   localparam logic [3:0] OP_OUT = 4'b1110;
   localparam logic [3:0] OP_HLT = 4'b1111;

   typedef enum logic [5:0] {
      T1 = 6'b000001,
      T2 = 6'b000010,
      T3 = 6'b000100,
      T4 = 6'b001000,
      T5 = 6'b010000,
      T6 = 6'b100000
   } tstate_e;

   tstate_e     state_q;
   tstate_e     state_d;
   logic        halted_q;
   logic        halted_d;
   // Control word order: Cp Ep Lm Er Li Ei La Ea Lb Su Eu Lo
   logic [11:0] ctl_s;

   // Ring and halt flag registers.
   always_ff @(posedge CLK or negedge CLR_n) begin
      if (!CLR_n) begin
         state_q  <= T1;
         halted_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         halted_q <= halted_d;
      end
   end

   // Next ring state. A halt leaves the ring parked on T5, the state after the edge ending T4.
   always_comb begin
      state_d  = state_q;
      halted_d = halted_q;
      if (!halted_q) begin
         case (state_q)
            T1: state_d = T2;
            T2: state_d = T3;
            T3: state_d = T4;
            T4: begin
               state_d = T5;
               if (bus.opcode == OP_HLT) begin
                  halted_d = 1'b1;
               end else begin
                  halted_d = 1'b0;
               end
            end
            T5: state_d = T6;
            T6: state_d = T1;
            default: state_d = T1;
         endcase
      end else begin
         state_d = state_q;
      end
   end

   // Control-word decode; everything is silenced while in reset or halted.
   always_comb begin
      ctl_s = 12'b0000_0000_0000;
      if (CLR_n && !halted_q) begin
         case (state_q)
            T1: ctl_s = 12'b0110_0000_0000;
            T2: ctl_s = 12'b1000_0000_0000;
            T3: ctl_s = 12'b0001_1000_0000;
            T4: begin
               case (bus.opcode)
                  OP_LDA, OP_ADD, OP_SUB: ctl_s = 12'b0010_0100_0000;
                  OP_OUT:                 ctl_s = 12'b0000_0001_0001;
                  default:                ctl_s = 12'b0000_0000_0000;
               endcase
            end
            T5: begin
               case (bus.opcode)
                  OP_LDA:         ctl_s = 12'b0001_0010_0000;
                  OP_ADD, OP_SUB: ctl_s = 12'b0001_0000_1000;
                  default:        ctl_s = 12'b0000_0000_0000;
               endcase
            end
            T6: begin
               case (bus.opcode)
                  OP_ADD:  ctl_s = 12'b0000_0010_0010;
                  OP_SUB:  ctl_s = 12'b0000_0010_0110;
                  default: ctl_s = 12'b0000_0000_0000;
               endcase
            end
            default: ctl_s = 12'b0000_0000_0000;
         endcase
      end else begin
         ctl_s = 12'b0000_0000_0000;
      end
   end

   assign {bus.Cp, bus.Ep, bus.Lm, bus.Er, bus.Li, bus.Ei,
           bus.La, bus.Ea, bus.Lb, bus.Su, bus.Eu, bus.Lo} = ctl_s;
   assign bus.HLT    = halted_q & CLR_n;
   assign bus.tstate = state_q;
endmodule
